control_cmd_readpixel_run: RTL and testbench
============================================

// Module: control_cmd_readpixel_run
// PURPOSE
// - Run-length successor to the single-pixel write command: after the command dispatcher selects it, parses row, column
//   and run length header bytes, then streams N pixels of BYTES_PER_PIXEL bytes each into framebuffer RAM.
// - Auto-increments pixel byte, then column, with column wrap; sits between the control byte demux and the RAM write arbiter.
// PARAMETERS
// - BYTES_PER_PIXEL  params_pkg::BYTES_PER_PIXEL  bytes per pixel, >=1
// - PIXEL_HEIGHT     params_pkg::PIXEL_HEIGHT     rows, <=256
// - PIXEL_WIDTH      params_pkg::PIXEL_WIDTH      columns, <=256
// - LEN_BYTES        2                            run-length header bytes, MSB first; max run 2^(8*LEN_BYTES)-1
// PORTS
// - clk               in   1       system clock
// - reset_n           in   1       asynchronous, active-low reset
// - enable            in   1       1-cycle strobe: data_in holds a valid byte this cycle
// - data_in           in   8       command byte stream
// - row               out  calc_pkg::num_row_address_bits(PIXEL_HEIGHT)           RAM row address
// - column            out  calc_pkg::num_column_address_bits(PIXEL_WIDTH)         RAM column address
// - pixel             out  calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)   byte-within-pixel address
// - data_out          out  8       RAM write data
// - ram_write_enable  out  1       high while a write is presented
// - ram_access_start  out  1       1-cycle strobe per RAM write
// - busy              out  1       high from first header byte until done
// - range_error       out  1       sticky until next command: header row/column out of range
// - done              out  1       1-cycle strobe at command completion
// BEHAVIOUR
// - Reset (reset_n=0, async): state=IDLE; all outputs 0; counters 0. Reset mid-run abandons the command, no further writes.
// - States: IDLE -> ROW -> COL -> LEN (LEN_BYTES bytes) -> DATA -> DONE -> IDLE. Transitions occur only on enable,
//   except DONE->IDLE (unconditional, 1 cycle) and LEN->DONE when length==0.
// - IDLE: first enable byte is row; busy=1, range_error cleared. ROW: next byte column. LEN: shift in length MSB first.
// - Row >= PIXEL_HEIGHT or column >= PIXEL_WIDTH: range_error=1; data bytes still consumed, writes suppressed.
// - DATA: pixel counter starts at BYTES_PER_PIXEL-1, decrements per byte (MSB-first pixel order).
// - Per data byte on cycle T: cycle T+1 drives data_out=byte, row/column/pixel = current address, ram_write_enable=1,
//   ram_access_start=1 (1 cycle). ram_write_enable falls at T+2 unless another byte arrives.
// - After pixel==0 written: pixel reloads BYTES_PER_PIXEL-1, column+1; column PIXEL_WIDTH-1 wraps to 0 (see CONFIGURATION).
// - Remaining-pixel counter (8*LEN_BYTES wide) decrements per completed pixel; reaching 0 -> DONE: done=1 one cycle
//   after the final ram_access_start; busy falls with done.
// - Length 0: no writes; done one cycle after final LEN byte.
// - enable in DONE cycle: byte treated as next command's row (IDLE semantics) — no byte is dropped.
// - Max enable rate: every cycle; no backpressure.
// CONFIGURATION
// - CONTROL_CMD_RUN_ROW_ADVANCE_EN defined: column wrap also advances row by 1, row PIXEL_HEIGHT-1 wraps to 0.
// - Not defined: column wraps to 0, row held at header value for entire run.
// TESTING (PIXEL_WIDTH=64, PIXEL_HEIGHT=32, BYTES_PER_PIXEL=2, LEN_BYTES=2; enable from divide-by-16 clock + ff_sync)
// - Bytes 03,05,00,01,AB,CD -> writes (r3,c5,p1,AB),(r3,c5,p0,CD); done 1 cycle after 2nd strobe; range_error=0.
// - Row 03, col 3E, len 0003, 6 data bytes -> columns 3E,3F,00; with _EN row 3,3,4; without _EN row 3,3,3.
// - Row 1F, col 3F, len 0002, _EN set -> 2nd pixel at r0,c0 (double wrap).
// - Row 20 (out of range), len 0002, 4 data bytes -> range_error=1, zero ram_access_start, done pulses once.
// - Len 0000 -> no writes; done 1 cycle after 2nd len byte; immediate next command parsed correctly.
// - reset_n low after 3rd data byte of a 4-pixel run -> outputs 0 at once; fresh command after release writes r/c as sent.

Source files
------------

// File: rtl/control_cmd_readpixel_run_if.sv
// -----------------------------------------------------------------------------
// control_cmd_readpixel_run_if
// Purpose : groups the byte-stream input and the framebuffer RAM write port of
//           the run-length pixel write command into one bundle.
// Params  : ROW_W / COL_W / PIX_W - widths of the RAM row, column and
//           byte-within-pixel addresses.
// Signals : enable, data_in             - command byte stream (1-cycle strobe)
//           row, column, pixel,
//           data_out, ram_write_enable,
//           ram_access_start            - RAM write request
//           busy, range_error, done     - command status
// Modports: slave  - the command block
//           master - the byte source / RAM side that drives it
// -----------------------------------------------------------------------------
interface control_cmd_readpixel_run_if #(
  parameter int ROW_W = 5,
  parameter int COL_W = 6,
  parameter int PIX_W = 1
);
  logic             enable;
  logic [7:0]       data_in;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] column;
  logic [PIX_W-1:0] pixel;
  logic [7:0]       data_out;
  logic             ram_write_enable;
  logic             ram_access_start;
  logic             busy;
  logic             range_error;
  logic             done;

  modport slave (
    input  enable, data_in,
    output row, column, pixel, data_out, ram_write_enable, ram_access_start,
           busy, range_error, done
  );

  modport master (
    output enable, data_in,
    input  row, column, pixel, data_out, ram_write_enable, ram_access_start,
           busy, range_error, done
  );
endinterface

// File: rtl/control_cmd_readpixel_run.sv
// -----------------------------------------------------------------------------
// control_cmd_readpixel_run
// Purpose : run-length pixel write command. Parses a row byte, a column byte
//           and LEN_BYTES run-length bytes (MSB first), then streams
//           length * BYTES_PER_PIXEL data bytes into framebuffer RAM, stepping
//           the byte-within-pixel address downwards and then the column.
// Ports   : clk      - system clock
//           reset_n  - asynchronous active-low reset
//           bus      - control_cmd_readpixel_run_if.slave (byte stream in,
//                      RAM write port and status out; all outputs registered)
// Options : define CONTROL_CMD_RUN_ROW_ADVANCE_EN to make a column wrap also
//           step the row (with row wrap). Without it the row stays at the
//           header value for the whole run.
// -----------------------------------------------------------------------------
module control_cmd_readpixel_run #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int PIXEL_WIDTH     = 64,
  parameter int LEN_BYTES       = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  control_cmd_readpixel_run_if.slave    bus
);

  localparam int ROW_W  = (PIXEL_HEIGHT > 1) ? $clog2(PIXEL_HEIGHT) : 1;
  localparam int COL_W  = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
  localparam int PIX_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int LCNT_W = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;

  localparam logic [7:0]        LAST_ROW  = 8'(PIXEL_HEIGHT - 1);
  localparam logic [7:0]        LAST_COL  = 8'(PIXEL_WIDTH - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(BYTES_PER_PIXEL - 1);
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LEN_BYTES - 1);

  // The IDLE state parses the row byte itself, so a command that starts in
  // the DONE cycle is handled exactly like one that starts from IDLE.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_COL  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q,    state_d;
  logic [7:0]          row_q,      row_d;       // working row (header value)
  logic [7:0]          col_q,      col_d;       // working column
  logic [PIX_W-1:0]    pix_q,      pix_d;       // byte-within-pixel counter
  logic [LEN_W-1:0]    len_q,      len_d;       // length shift reg, then pixels left
  logic [LCNT_W-1:0]   lcnt_q,     lcnt_d;      // length byte index
  logic                zero_len_q, zero_len_d;  // run had length 0
  logic                err_q,      err_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [ROW_W-1:0]    row_o_q,    row_o_d;
  logic [COL_W-1:0]    col_o_q,    col_o_d;
  logic [PIX_W-1:0]    pix_o_q,    pix_o_d;
  logic [7:0]          dout_q,     dout_d;
  logic                we_q,       we_d;
  logic                start_q,    start_d;
  logic [LEN_W-1:0]    new_len_s;

  assign new_len_s = (len_q << 4'd8) | LEN_W'(bus.data_in);

  // Next-state and output decode for the command parser.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pix_d      = pix_q;
    len_d      = len_q;
    lcnt_d     = lcnt_q;
    zero_len_d = zero_len_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    row_o_d    = row_o_q;
    col_o_d    = col_o_q;
    pix_o_d    = pix_o_q;
    dout_d     = dout_q;
    we_d       = 1'b0;
    start_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          row_d   = bus.data_in;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_COL;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COL: begin
        if (bus.enable) begin
          col_d   = bus.data_in;
          err_d   = (int'(row_q) >= PIXEL_HEIGHT) || (int'(bus.data_in) >= PIXEL_WIDTH);
          len_d   = {LEN_W{1'b0}};
          lcnt_d  = {LCNT_W{1'b0}};
          state_d = S_LEN;
        end else begin
          state_d = S_COL;
        end
      end

      S_LEN: begin
        if (bus.enable) begin
          len_d = new_len_s;
          if (lcnt_q == LCNT_LAST) begin
            if (new_len_s == {LEN_W{1'b0}}) begin
              // Empty run: done is raised straight away, one cycle after the
              // last length byte.
              zero_len_d = 1'b1;
              done_d     = 1'b1;
              busy_d     = 1'b0;
              state_d    = S_DONE;
            end else begin
              zero_len_d = 1'b0;
              pix_d      = PIX_LAST;
              state_d    = S_DATA;
            end
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end else begin
          state_d = S_LEN;
        end
      end

      S_DATA: begin
        if (bus.enable) begin
          // Out-of-range runs still consume their bytes, only the write is dropped.
          if (!err_q) begin
            we_d    = 1'b1;
            start_d = 1'b1;
            dout_d  = bus.data_in;
            row_o_d = ROW_W'(row_q);
            col_o_d = COL_W'(col_q);
            pix_o_d = pix_q;
          end else begin
            we_d    = 1'b0;
            start_d = 1'b0;
          end
          if (pix_q == {PIX_W{1'b0}}) begin
            pix_d = PIX_LAST;
            len_d = len_q - LEN_W'(1);
            if (col_q == LAST_COL) begin
              col_d = 8'd0;
`ifdef CONTROL_CMD_RUN_ROW_ADVANCE_EN
              if (row_q == LAST_ROW) begin
                row_d = 8'd0;
              end else begin
                row_d = row_q + 8'd1;
              end
`else
              row_d = row_q;
`endif
            end else begin
              col_d = col_q + 8'd1;
            end
            if (len_q == LEN_W'(1)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            pix_d = pix_q - PIX_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_DONE: begin
        // For a non-empty run done lands one cycle after the final write strobe.
        done_d = ~zero_len_q;
        busy_d = 1'b0;
        if (bus.enable) begin
          row_d   = bus.data_in;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_COL;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      row_q      <= 8'd0;
      col_q      <= 8'd0;
      pix_q      <= {PIX_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      lcnt_q     <= {LCNT_W{1'b0}};
      zero_len_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      row_o_q    <= {ROW_W{1'b0}};
      col_o_q    <= {COL_W{1'b0}};
      pix_o_q    <= {PIX_W{1'b0}};
      dout_q     <= 8'd0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pix_q      <= pix_d;
      len_q      <= len_d;
      lcnt_q     <= lcnt_d;
      zero_len_q <= zero_len_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      row_o_q    <= row_o_d;
      col_o_q    <= col_o_d;
      pix_o_q    <= pix_o_d;
      dout_q     <= dout_d;
      we_q       <= we_d;
      start_q    <= start_d;
    end
  end

  assign bus.row              = row_o_q;
  assign bus.column           = col_o_q;
  assign bus.pixel            = pix_o_q;
  assign bus.data_out         = dout_q;
  assign bus.ram_write_enable = we_q;
  assign bus.ram_access_start = start_q;
  assign bus.busy             = busy_q;
  assign bus.range_error      = err_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_control_cmd_readpixel_run.sv
// -----------------------------------------------------------------------------
// tb_control_cmd_readpixel_run
// Bench for control_cmd_readpixel_run with a 64x32 framebuffer, 2 bytes per
// pixel and a 2-byte run length. Directed commands come from a table, a few
// hand-written sequences cover back-to-back commands and reset mid-run, and
// random commands are checked against a write-list model computed from the
// run's arithmetic (pixel index -> column/row with modulo wrap).
// -----------------------------------------------------------------------------
module tb_control_cmd_readpixel_run;
  localparam int W   = 64;
  localparam int H   = 32;
  localparam int BPP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_cmd_readpixel_run_if #(.ROW_W(5), .COL_W(6), .PIX_W(1)) bus ();

  control_cmd_readpixel_run #(
    .BYTES_PER_PIXEL(BPP), .PIXEL_HEIGHT(H), .PIXEL_WIDTH(W), .LEN_BYTES(2)
  ) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_cyc = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the RAM port away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ram_access_start) begin
        obs_q.push_back({8'(bus.row), 8'(bus.column), 8'(bus.pixel), bus.data_out});
        start_cnt++;
      end
      if (bus.ram_write_enable) we_cnt++;
      if (bus.done) done_q.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_q.delete();
    we_cnt = 0;
    start_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.data_in = b;
    bus.enable = 1'b1;
    @(negedge clk);
    last_cyc = cyc;
    bus.enable = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Expected write list: byte i of the run belongs to pixel i/BPP, bytes go
  // most-significant first, pixel k sits k columns past the header column.
  function automatic void model(input int r, input int c, input int n, input logic [7:0] d[$]);
    int k, p, cc, rr;
    exp_q.delete();
    if (r >= H || c >= W) return;
    for (int i = 0; i < n * BPP; i++) begin
      k  = i / BPP;
      p  = BPP - 1 - (i % BPP);
      cc = (c + k) % W;
`ifdef CONTROL_CMD_RUN_ROW_ADVANCE_EN
      rr = (r + (c + k) / W) % H;
`else
      rr = r;
`endif
      exp_q.push_back({8'(rr), 8'(cc), 8'(p), d[i]});
    end
  endfunction

  task automatic run_cmd(input int r, input int c, input int n, input int maxgap,
                         input string nm);
    logic [7:0] d[$];
    int exp_done;
    clear_obs();
    for (int i = 0; i < n * BPP; i++) d.push_back(8'($urandom));
    model(r, c, n, d);
    send_byte(8'(r), $urandom_range(0, maxgap));
    send_byte(8'(c), $urandom_range(0, maxgap));
    send_byte(8'(n >> 8), $urandom_range(0, maxgap));
    send_byte(8'(n), (n == 0) ? 0 : $urandom_range(0, maxgap));
    foreach (d[i]) send_byte(d[i], (i == d.size() - 1) ? 0 : $urandom_range(0, maxgap));
    exp_done = (n == 0) ? last_cyc : last_cyc + 1;
    repeat (6) @(negedge clk);
    chk({nm, " nwrites"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) chk({nm, " write"}, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
    chk({nm, " done_count"}, done_q.size(), 1);
    chk({nm, " done_cycle"}, (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    chk({nm, " range_error"}, bus.range_error, (r >= H || c >= W) ? 1 : 0);
    chk({nm, " busy_end"}, bus.busy, 0);
    chk({nm, " we_vs_start"}, we_cnt, start_cnt);
  endtask

  typedef struct {
    int r; int c; int n; int maxgap; int nwr; int lrow; int lcol;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int lr, lc, k;
    bus.enable = 1'b0;
    bus.data_in = 8'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst row", bus.row, 0);
    chk("rst column", bus.column, 0);
    chk("rst pixel", bus.pixel, 0);
    chk("rst data_out", bus.data_out, 0);
    chk("rst we", bus.ram_write_enable, 0);
    chk("rst start", bus.ram_access_start, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst range_error", bus.range_error, 0);
    chk("rst done", bus.done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef CONTROL_CMD_RUN_ROW_ADVANCE_EN
    lr = 4; lc = 0;
`else
    lr = 3; lc = 3;
`endif
    tbl[0] = '{r: 3,  c: 5,  n: 1, maxgap: 15, nwr: 2, lrow: 3,  lcol: 5};
    tbl[1] = '{r: 3,  c: 62, n: 3, maxgap: 0,  nwr: 6, lrow: lr, lcol: 0};
`ifdef CONTROL_CMD_RUN_ROW_ADVANCE_EN
    tbl[2] = '{r: 31, c: 63, n: 2, maxgap: 2,  nwr: 4, lrow: 0,  lcol: 0};
`else
    tbl[2] = '{r: 31, c: 63, n: 2, maxgap: 2,  nwr: 4, lrow: 31, lcol: 0};
`endif
    tbl[3] = '{r: 32, c: 0,  n: 2, maxgap: 1,  nwr: 0, lrow: 0,  lcol: 0};
    tbl[4] = '{r: 0,  c: 64, n: 1, maxgap: 0,  nwr: 0, lrow: 0,  lcol: 0};
    tbl[5] = '{r: 0,  c: 0,  n: 0, maxgap: 0,  nwr: 0, lrow: 0,  lcol: 0};
    tbl[6] = '{r: 31, c: 63, n: 1, maxgap: 3,  nwr: 2, lrow: 31, lcol: 63};

    foreach (tbl[i]) begin
      run_cmd(tbl[i].r, tbl[i].c, tbl[i].n, tbl[i].maxgap, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d start_count", i), start_cnt, tbl[i].nwr);
      if (tbl[i].nwr > 0) begin
        k = obs_q.size();
        chk($sformatf("tbl%0d last_row", i), (k > 0) ? int'(obs_q[k-1][31:24]) : -1, tbl[i].lrow);
        chk($sformatf("tbl%0d last_col", i), (k > 0) ? int'(obs_q[k-1][23:16]) : -1, tbl[i].lcol);
      end
    end

    // Empty run immediately followed by a command whose row byte lands in DONE.
    clear_obs();
    send_byte(8'h02, 0); send_byte(8'h07, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    lr = last_cyc;
    send_byte(8'h04, 0); send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    lc = last_cyc;
    repeat (6) @(negedge clk);
    chk("b2b done_count", done_q.size(), 2);
    chk("b2b done0_cycle", (done_q.size() > 0) ? done_q[0] : -1, lr);
    chk("b2b done1_cycle", (done_q.size() > 1) ? done_q[1] : -1, lc + 1);
    chk("b2b nwrites", obs_q.size(), 2);
    chk("b2b write0", (obs_q.size() > 0) ? obs_q[0] : -1, 32'h04090111);
    chk("b2b write1", (obs_q.size() > 1) ? obs_q[1] : -1, 32'h04090022);

    // Reset after the third data byte of a 4-pixel run.
    clear_obs();
    send_byte(8'h05, 0); send_byte(8'h06, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'hA1, 0); send_byte(8'hA2, 0); send_byte(8'hA3, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst we", bus.ram_write_enable, 0);
    chk("midrst start", bus.ram_access_start, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst data_out", bus.data_out, 0);
    chk("midrst column", bus.column, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    send_byte(8'hB1, 0);   // would be data for the abandoned run; now a row byte
    repeat (6) @(negedge clk);
    chk("midrst no_writes", obs_q.size(), 0);
    chk("midrst busy_partial", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(7, 8, 1, 0, "post_rst");

    // Random commands, including out-of-range headers and empty runs.
    for (int i = 0; i < 25; i++)
      run_cmd($urandom_range(0, 34), $urandom_range(0, 66), $urandom_range(0, 4),
              3, $sformatf("rnd%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
